// File: rtl/pool_collator.sv
// Streaming pooling reducer: folds every WINDOW accepted beats into one max or
// floor-average result per lane, with valid/ready flow control on both sides.
module pool_collator #(
  parameter int unsigned DATA_W   = 20,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WINDOW   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode_avg,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHANNELS*DATA_W-1:0] out_data
);

  localparam int unsigned CW = $clog2(WINDOW);
  localparam int unsigned AW = DATA_W + CW;

  logic [CW-1:0]             cnt;
  logic                      mode_q;
  logic [AW-1:0]             acc      [CHANNELS];
  logic [AW-1:0]             lane_ext [CHANNELS];
  logic [AW-1:0]             combined [CHANNELS];
  logic [AW-1:0]             acc_d    [CHANNELS];
  logic [CHANNELS*DATA_W-1:0] result;
  logic                      is_first;
  logic                      is_last;
  logic                      accept;

  assign is_first = (cnt == '0);
  assign is_last  = (cnt == CW'(WINDOW - 1));
  // Only the closing beat of a window waits on the output register.
  assign in_ready = !flush && (!is_last || !out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Per-lane combine of accumulator and incoming beat, plus final scaling.
  always_comb begin
    result = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      lane_ext[k] = AW'(in_data[k*DATA_W +: DATA_W]);
      if (mode_q)
        combined[k] = acc[k] + lane_ext[k];
      else
        combined[k] = (lane_ext[k] > acc[k]) ? lane_ext[k] : acc[k];
      acc_d[k] = is_first ? lane_ext[k] : combined[k];
      if (mode_q)
        result[k*DATA_W +: DATA_W] = DATA_W'(combined[k] >> CW);
      else
        result[k*DATA_W +: DATA_W] = combined[k][DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int k = 0; k < CHANNELS; k++) acc[k] <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (flush) begin
        cnt <= '0;
      end else if (accept) begin
        for (int k = 0; k < CHANNELS; k++) acc[k] <= acc_d[k];
        if (is_first) mode_q <= mode_avg;
        if (is_last) begin
          cnt       <= '0;
          out_valid <= 1'b1;
          out_data  <= result;
        end else begin
          cnt <= CW'(cnt + 1'b1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_collator.sv
// Self-checking bench for pool_collator: directed scenarios plus random traffic
// against a queue-based window model.
module tb_pool_collator;

  localparam int unsigned DATA_W   = 20;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned WINDOW   = 4;
  localparam int unsigned BW       = CHANNELS * DATA_W;

  typedef logic [BW-1:0] beat_t;

  logic  clk = 1'b0;
  logic  rst, mode_avg, flush, in_valid, in_ready, out_valid, out_ready;
  beat_t in_data, out_data;

  always #5 clk = ~clk;

  pool_collator #(.DATA_W(DATA_W), .CHANNELS(CHANNELS), .WINDOW(WINDOW)) dut (
    .clk(clk), .rst(rst), .mode_avg(mode_avg), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference state: beats of the open window, its mode, and the output slot.
  beat_t win[$];
  logic  wmode;
  logic  pv;
  beat_t pd;

  task automatic check(input string tag, input beat_t obs, input beat_t exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic beat_t reduce(input beat_t q[$], input logic m);
    beat_t r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      longint unsigned s = 0, mx = 0, v;
      foreach (q[i]) begin
        v = 64'(q[i][k*DATA_W +: DATA_W]);
        s += v;
        if (v > mx) mx = v;
      end
      r[k*DATA_W +: DATA_W] = m ? DATA_W'(s / WINDOW) : DATA_W'(mx);
    end
    return r;
  endfunction

  function automatic beat_t pack2(input int unsigned a, input int unsigned b);
    beat_t x = '0;
    x[DATA_W-1:0]        = DATA_W'(a);
    x[2*DATA_W-1:DATA_W] = DATA_W'(b);
    return x;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t x = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      case ($urandom_range(0, 3))
        0:       x[k*DATA_W +: DATA_W] = '1;
        1:       x[k*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 3));
        default: x[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      endcase
    end
    return x;
  endfunction

  // Apply one cycle of inputs, check outputs against the model, advance model.
  task automatic step(input logic r, input logic m, input logic f, input logic v,
                      input beat_t d, input logic ordy);
    logic exp_ready, acc, hs;
    rst = r; mode_avg = m; flush = f; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    exp_ready = !f && (win.size() != WINDOW - 1 || !pv || ordy);
    check("in_ready", BW'(in_ready), BW'(exp_ready));
    check("out_valid", BW'(out_valid), BW'(pv));
    check("out_data", out_data, pd);
    acc = v && exp_ready;
    hs  = pv && ordy;
    if (r) begin
      win.delete();
      pv = 1'b0;
      pd = '0;
    end else begin
      if (hs) pv = 1'b0;
      if (f) begin
        win.delete();
      end else if (acc) begin
        if (win.size() == 0) wmode = m;
        win.push_back(d);
        if (win.size() == WINDOW) begin
          pd = reduce(win, wmode);
          pv = 1'b1;
          win.delete();
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mode_avg = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1;
    win.delete(); wmode = 1'b0; pv = 1'b0; pd = '0;
    @(negedge clk);
    @(negedge clk);

    // Max mode
    step(0, 0, 0, 1, pack2(3, 7), 1);
    step(0, 0, 0, 1, pack2(9, 7), 1);
    step(0, 0, 0, 1, pack2(5, 2), 1);
    step(0, 0, 0, 1, pack2(1, 8), 1);
    check("max_result", out_data, pack2(9, 8));
    step(0, 0, 0, 0, '0, 1);

    // Average mode, then full-scale average
    step(0, 1, 0, 1, pack2(3, 7), 1);
    step(0, 1, 0, 1, pack2(9, 7), 1);
    step(0, 1, 0, 1, pack2(5, 2), 1);
    step(0, 1, 0, 1, pack2(1, 8), 1);
    check("avg_result", out_data, pack2(4, 6));
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, '1, 1);
    check("avg_full_scale", out_data, '1);

    // Mode latched on the first beat only
    step(0, 1, 0, 1, pack2(3, 0), 1);
    step(0, 0, 0, 1, pack2(9, 0), 1);
    step(0, 0, 0, 1, pack2(5, 0), 1);
    step(0, 0, 0, 1, pack2(1, 0), 1);
    check("mode_latch_avg", out_data, pack2(4, 0));
    step(0, 0, 0, 1, pack2(3, 0), 1);
    step(0, 1, 0, 1, pack2(9, 0), 1);
    step(0, 1, 0, 1, pack2(5, 0), 1);
    step(0, 1, 0, 1, pack2(1, 0), 1);
    check("mode_latch_max", out_data, pack2(9, 0));

    // Backpressure: next window's last beat waits, then both handshakes coincide
    step(0, 0, 0, 1, pack2(10, 1), 0);
    step(0, 0, 0, 1, pack2(20, 1), 0);
    step(0, 0, 0, 1, pack2(30, 1), 0);
    check("bp_hold_valid", BW'(out_valid), BW'(1));
    check("bp_hold_data", out_data, pack2(9, 0));
    step(0, 0, 0, 1, pack2(40, 1), 0);
    check("bp_stall_ready", BW'(in_ready), BW'(0));
    step(0, 0, 0, 1, pack2(40, 1), 0);
    step(0, 0, 0, 1, pack2(40, 1), 1);
    check("bp_swap_valid", BW'(out_valid), BW'(1));
    check("bp_swap_data", out_data, pack2(40, 1));
    step(0, 0, 0, 0, '0, 0);

    // Flush with a pending result held across it
    step(0, 0, 0, 1, pack2(100, 0), 0);
    step(0, 0, 0, 1, pack2(200, 0), 0);
    step(0, 0, 1, 1, pack2(999, 0), 0);
    check("flush_keeps_result", out_data, pack2(40, 1));
    step(0, 0, 0, 1, pack2(1, 0), 1);
    step(0, 0, 0, 1, pack2(2, 0), 1);
    step(0, 0, 0, 1, pack2(3, 0), 1);
    step(0, 0, 0, 1, pack2(4, 0), 1);
    check("flush_result", out_data, pack2(4, 0));

    // Reset mid-window with a pending result
    step(0, 0, 0, 1, pack2(50, 0), 0);
    step(0, 0, 0, 1, pack2(60, 0), 0);
    step(0, 0, 0, 1, pack2(70, 0), 0);
    step(1, 0, 0, 1, pack2(80, 0), 0);
    check("rst_out_valid", BW'(out_valid), BW'(0));
    check("rst_out_data", out_data, '0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, pack2(4 * i + 2, 0), 1);
    check("post_rst_result", out_data, pack2(8, 0));

    // Random traffic
    for (int i = 0; i < 4000; i++)
      step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0),
           rnd_beat(), 1'($urandom_range(0, 3) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
